sync_filt_nv_c_pp: RTL and testbench

SYNC_FILT_NV_C_PP -- requirements
Module: sync_filt_nv_c_pp

---
 rtl/sync_filt_nv_c_pp_pkg.sv | 21 ++
 rtl/sync_filt_bit_c_pp.sv | 66 ++++++
 rtl/sync_filt_nv_c_pp.sv | 43 ++++
 tb/tb_sync_filt_nv_c_pp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sync_filt_nv_c_pp_pkg.sv
// rtl/sync_filt_nv_c_pp_pkg.sv - shared limits, defaults and counter sizing for the sync filter
package sync_filt_nv_c_pp_pkg;

   localparam int WIDTH_MAX    = 32;
   localparam int STAGES_MIN   = 2;
   localparam int STAGES_MAX   = 4;
   localparam int FILT_CYC_MAX = 255;

   localparam int DEF_WIDTH    = 1;
   localparam int DEF_STAGES   = 2;
   localparam int DEF_FILT_CYC = 0;

   // Bits needed to hold 0..filt_cyc; never below 1 so the counter always exists.
   function automatic int cnt_width(input int filt_cyc);
      cnt_width = 1;
      for (int i = 1; i < 9; i++) begin
         if ((1 << i) < (filt_cyc + 1)) cnt_width = i + 1;
      end
   endfunction

endpackage

// File: rtl/sync_filt_bit_c_pp.sv
// rtl/sync_filt_bit_c_pp.sv - one-bit synchronizer chain with persistence filter and edge/glitch flags
module sync_filt_bit_c_pp
   import sync_filt_nv_c_pp_pkg::*;
#(
   parameter int   STAGES    = DEF_STAGES,
   parameter int   FILT_CYC  = DEF_FILT_CYC,
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic clr_,
   input  logic d,
   input  logic glitch_clr,
   output logic q,
   output logic rise,
   output logic fall,
   output logic glitch
);

   localparam int             CW       = cnt_width(FILT_CYC);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYC - 1);

   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", dont_retime = "true", preserve = "true" *)
   logic [STAGES-1:0] sync_ff;

   logic          s;
   logic          q_reg;
   logic          q_prev;
   logic          glitch_reg;
   logic [CW-1:0] cnt;
   logic          aborted;

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) sync_ff <= {STAGES{RESET_BIT}};
      else       sync_ff <= {sync_ff[STAGES-2:0], d};
   end

   assign s       = sync_ff[STAGES-1];
   assign aborted = (s == q_reg) && (cnt != '0);

   // Filter state exists for every FILT_CYC; with FILT_CYC=0 it is simply not observed.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         q_reg      <= RESET_BIT;
         q_prev     <= RESET_BIT;
         cnt        <= '0;
         glitch_reg <= 1'b0;
      end else begin
         q_prev     <= q;
         glitch_reg <= aborted | (glitch_reg & ~glitch_clr);
         if (s == q_reg) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            q_reg <= s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign q      = (FILT_CYC == 0) ? s : q_reg;
   assign glitch = (FILT_CYC == 0) ? 1'b0 : glitch_reg;
   assign rise   = q & ~q_prev;
   assign fall   = ~q & q_prev;

endmodule

// File: rtl/sync_filt_nv_c_pp.sv
// rtl/sync_filt_nv_c_pp.sv - multi-bit asynchronous input synchronizer with optional glitch filter
module sync_filt_nv_c_pp
   import sync_filt_nv_c_pp_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               STAGES    = DEF_STAGES,
   parameter int               FILT_CYC  = DEF_FILT_CYC,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr_,
   input  logic [WIDTH-1:0] d,
   input  logic             glitch_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] glitch
);

   if (WIDTH < 1 || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
       FILT_CYC < 0 || FILT_CYC > FILT_CYC_MAX) begin : g_bad_param
      $error("sync_filt_nv_c_pp: parameter out of range");
   end

   // Bits are independent; multi-bit buses must be gray-coded upstream.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sync_filt_bit_c_pp #(
         .STAGES    (STAGES),
         .FILT_CYC  (FILT_CYC),
         .RESET_BIT (RESET_VAL[i])
      ) u_bit (
         .clk        (clk),
         .clr_       (clr_),
         .d          (d[i]),
         .glitch_clr (glitch_clr),
         .q          (q[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .glitch     (glitch[i])
      );
   end

endmodule

// File: tb/tb_sync_filt_nv_c_pp.sv
// tb/tb_sync_filt_nv_c_pp.sv - directed self-checking bench for sync_filt_nv_c_pp
module tb_sync_filt_nv_c_pp;

   logic clk;
   logic clr_;
   logic clr_d;
   logic d_a, d_b, d_c, d_d;
   logic gclr_c;
   logic [7:0] d_e;
   logic gclr_e;
   logic q_a, rise_a, fall_a, glitch_a;
   logic q_b, rise_b, fall_b, glitch_b;
   logic q_c, rise_c, fall_c, glitch_c;
   logic q_d, rise_d, fall_d, glitch_d;
   logic [7:0] q_e, rise_e, fall_e, glitch_e;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [7:0] d;
      logic       gclr;
      logic [7:0] q;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] glitch;
   } vec_t;

   vec_t vec [15];

   sync_filt_nv_c_pp #(.WIDTH(1), .STAGES(2), .FILT_CYC(0)) dut_a (
      .clk(clk), .clr_(clr_), .d(d_a), .glitch_clr(1'b0),
      .q(q_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a));

   sync_filt_nv_c_pp #(.WIDTH(1), .STAGES(3), .FILT_CYC(4)) dut_b (
      .clk(clk), .clr_(clr_), .d(d_b), .glitch_clr(1'b0),
      .q(q_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b));

   sync_filt_nv_c_pp #(.WIDTH(1), .STAGES(2), .FILT_CYC(4)) dut_c (
      .clk(clk), .clr_(clr_), .d(d_c), .glitch_clr(gclr_c),
      .q(q_c), .rise(rise_c), .fall(fall_c), .glitch(glitch_c));

   sync_filt_nv_c_pp #(.WIDTH(1), .STAGES(2), .FILT_CYC(4), .RESET_VAL(1'b1)) dut_d (
      .clk(clk), .clr_(clr_d), .d(d_d), .glitch_clr(1'b0),
      .q(q_d), .rise(rise_d), .fall(fall_d), .glitch(glitch_d));

   sync_filt_nv_c_pp #(.WIDTH(8), .STAGES(2), .FILT_CYC(2)) dut_e (
      .clk(clk), .clr_(clr_), .d(d_e), .glitch_clr(gclr_e),
      .q(q_e), .rise(rise_e), .fall(fall_e), .glitch(glitch_e));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rises;

      vec[0]  = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
      vec[1]  = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
      vec[2]  = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
      vec[3]  = '{8'hA5, 1'b0, 8'hA5, 8'hA5, 8'h00, 8'h00};
      vec[4]  = '{8'h5A, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00};
      vec[5]  = '{8'h5A, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00};
      vec[6]  = '{8'h5A, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00};
      vec[7]  = '{8'h5A, 1'b0, 8'h5A, 8'h5A, 8'hA5, 8'h00};
      vec[8]  = '{8'h5A, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00};
      vec[9]  = '{8'hFF, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00};
      vec[10] = '{8'h5A, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00};
      vec[11] = '{8'h5A, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00};
      vec[12] = '{8'h5A, 1'b0, 8'h5A, 8'h00, 8'h00, 8'hA5};
      vec[13] = '{8'h5A, 1'b0, 8'h5A, 8'h00, 8'h00, 8'hA5};
      vec[14] = '{8'h5A, 1'b1, 8'h5A, 8'h00, 8'h00, 8'h00};

      clr_ = 1'b0; clr_d = 1'b0;
      d_a = 1'b0; d_b = 1'b0; d_c = 1'b0; d_d = 1'b1; d_e = 8'h00;
      gclr_c = 1'b0; gclr_e = 1'b0;
      step(); step();

      chk("reset_q_a", q_a, 0);
      chk("reset_q_d", q_d, 1);
      chk("reset_edges_d", {rise_d, fall_d, glitch_d}, 0);
      chk("reset_q_e", q_e, 0);
      chk("reset_flags_e", {rise_e, fall_e, glitch_e}, 0);
      clr_ = 1'b1; clr_d = 1'b1;

      // Bypass: two-stage latency, single rise pulse.
      d_a = 1'b1;
      step(); chk("a_q_e1", q_a, 0);
      step(); chk("a_q_e2", q_a, 1); chk("a_rise_e2", rise_a, 1); chk("a_fall_e2", fall_a, 0);
      step(); chk("a_rise_e3", rise_a, 0); chk("a_q_e3", q_a, 1);

      // Three stages plus four filter cycles: q rises after edge 7.
      rises = 0;
      d_b = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (rise_b) rises++;
         chk($sformatf("b_q_e%0d", n), q_b, (n >= 7) ? 1 : 0);
         chk($sformatf("b_rise_e%0d", n), rise_b, (n == 7) ? 1 : 0);
         chk($sformatf("b_glitch_e%0d", n), glitch_b, 0);
      end
      chk("b_rise_count", rises, 1);

      // Three-cycle pulse is rejected and flagged.
      for (int n = 1; n <= 8; n++) begin
         d_c = (n <= 3);
         step();
         chk($sformatf("c_q_e%0d", n), q_c, 0);
         chk($sformatf("c_glitch_e%0d", n), glitch_c, (n >= 6) ? 1 : 0);
      end
      gclr_c = 1'b1;
      step();
      gclr_c = 1'b0;
      chk("c_glitch_cleared", glitch_c, 0);

      // Glitch set coinciding with glitch_clr: set wins.
      for (int n = 1; n <= 6; n++) begin
         d_c = (n <= 3);
         gclr_c = (n == 6);
         step();
         chk($sformatf("c2_glitch_e%0d", n), glitch_c, (n == 6) ? 1 : 0);
      end
      gclr_c = 1'b0;
      step();
      chk("c2_glitch_sticky", glitch_c, 1);
      chk("c2_q", q_c, 0);

      // Asynchronous reset mid-count, RESET_VAL=1.
      d_d = 1'b0;
      for (int n = 1; n <= 5; n++) step();
      chk("d_cnt_before", dut_d.g_bit[0].u_bit.cnt, 3);
      chk("d_q_before", q_d, 1);
      clr_d = 1'b0;
      #1;
      chk("d_cnt_async", dut_d.g_bit[0].u_bit.cnt, 0);
      chk("d_q_async", q_d, 1);
      chk("d_edges_async", {rise_d, fall_d}, 0);
      d_d = 1'b1;
      step(); step();
      clr_d = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         step();
         chk($sformatf("d_q_rel%0d", n), q_d, 1);
         chk($sformatf("d_edges_rel%0d", n), {rise_d, fall_d}, 0);
      end

      // Eight independent bits, FILT_CYC=2.
      for (int i = 0; i < 15; i++) begin
         d_e = vec[i].d;
         gclr_e = vec[i].gclr;
         step();
         chk($sformatf("e_q_row%0d", i), q_e, vec[i].q);
         chk($sformatf("e_rise_row%0d", i), rise_e, vec[i].rise);
         chk($sformatf("e_fall_row%0d", i), fall_e, vec[i].fall);
         chk($sformatf("e_glitch_row%0d", i), glitch_e, vec[i].glitch);
      end
      gclr_e = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
